// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
// The PIPE state is only reachable with INV_SUB_BYTES_PIPE_EN.
package aes_pkg;

    localparam int AES_STATE_W  = 128;
    localparam int AES_NB_BYTES = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        PIPE,
        DONE
    } isb_state_e;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, one byte, purely combinational.
// Table indexed directly by the input byte.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] b_o
);

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign b_o = INV_SBOX[a_i];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES bytes per cycle, result held until taken.
// INV_SUB_BYTES_PIPE_EN registers S-box outputs and adds a drain state.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int CHUNKS = AES_NB_BYTES / LANES;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int LW = LANES * 8;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    isb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] out_q, out_d;
    logic [AES_STATE_W-1:0] wb;
    logic [LW-1:0] sb_in, sb_out;
    logic last;

    assign sb_in = work_q[int'(cnt_q)*LW +: LW];
    assign last  = (cnt_q == LAST);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_sbox (
            .a_i (sb_in[l*8 +: 8]),
            .b_o (sb_out[l*8 +: 8])
        );
    end

`ifdef INV_SUB_BYTES_PIPE_EN
    logic [LW-1:0] pipe_q, pipe_d;
    logic [CW-1:0] pidx_q, pidx_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        wb      = work_q;
`ifdef INV_SUB_BYTES_PIPE_EN
        pipe_d  = pipe_q;
        pidx_d  = pidx_q;
        wb[int'(pidx_q)*LW +: LW] = pipe_q;
`else
        wb[int'(cnt_q)*LW +: LW] = sb_out;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
`ifdef INV_SUB_BYTES_PIPE_EN
                // chunk cnt-1 is still in the pipe register
                if (cnt_q != '0) work_d = wb;
                pipe_d = sb_out;
                pidx_d = cnt_q;
                if (last) state_d = PIPE;
`else
                work_d = wb;
                if (last) begin
                    out_d   = wb;
                    state_d = DONE;
                end
`endif
            end
`ifdef INV_SUB_BYTES_PIPE_EN
            PIPE: begin
                work_d  = wb;
                out_d   = wb;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
`ifdef INV_SUB_BYTES_PIPE_EN
            pipe_q  <= '0;
            pidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
`ifdef INV_SUB_BYTES_PIPE_EN
            pipe_q  <= pipe_d;
            pidx_q  <= pidx_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_state = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: LANES 1, 4 and 16 side by side
// against a transaction-level model built from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

    localparam int N = 3;
`ifdef INV_SUB_BYTES_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    function automatic int lanes_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    endfunction

    logic clk = 0;
    logic rst;
    logic iv [N];
    logic ir [N];
    logic ov [N];
    logic orr [N];
    logic bz [N];
    logic [127:0] is_ [N];
    logic [127:0] os [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        inv_sub_bytes_iter #(.LANES(lanes_of(g))) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_state  (is_[g]),
            .out_valid (ov[g]),
            .out_ready (orr[g]),
            .out_state (os[g]),
            .busy      (bz[g])
        );
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference inverse S-box derived from the forward affine map
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref();
        logic [7:0] x, y, s;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            y = 8'h00;
            for (int j = 1; j < 256; j++)
                if (x != 0 && gmul(x, 8'(j)) == 8'h01) y = 8'(j);
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4)
                ^ 8'h63;
            isb[s] = x;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] v);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = isb[v[b*8 +: 8]];
        return r;
    endfunction

    // transaction model: cycles left, holding flag, last result
    int m_rem [N];
    bit m_hold [N];
    logic [127:0] m_res [N];
    logic [127:0] m_out [N];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_rem[i]  <= 0;
                m_hold[i] <= 0;
                m_out[i]  <= '0;
            end else if (m_hold[i]) begin
                if (orr[i]) m_hold[i] <= 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i] <= m_rem[i] - 1;
                if (m_rem[i] == 1) begin
                    m_hold[i] <= 1;
                    m_out[i]  <= m_res[i];
                end
            end else if (iv[i]) begin
                m_rem[i] <= 16 / lanes_of(i) + P;
                m_res[i] <= ref_sub(is_[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("ov%0d", i), 128'(ov[i]), 128'(m_hold[i]));
                chk($sformatf("ir%0d", i), 128'(ir[i]),
                    128'(!m_hold[i] && m_rem[i] == 0));
                chk($sformatf("busy%0d", i), 128'(bz[i]),
                    128'(m_rem[i] > P));
                chk($sformatf("os%0d", i), os[i], m_out[i]);
            end
        end
    end

    task automatic send(input int i, input logic [127:0] s,
                        output int k);
        logic a = 0;
        int n = 0;
        iv[i] = 1;
        is_[i] = s;
        while (!a && n < 200) begin
            a = ir[i];
            @(posedge clk);
            #1;
            n++;
        end
        if (!a) chk($sformatf("send_to%0d", i), 128'(0), 128'(1));
        k = cyc;
    endtask

    task automatic wait_ov(input int i, output int n);
        n = 0;
        while (!ov[i] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov[i]) chk($sformatf("wait_to%0d", i), 128'(0), 128'(1));
    endtask

    initial begin
        int k, n;
        int t [16];
        logic [127:0] r, st;
        rst = 1;
        for (int i = 0; i < N; i++) begin
            iv[i] = 0;
            orr[i] = 0;
            is_[i] = '0;
        end
        build_ref();
        chk("ref63", 128'(isb[8'h63]), 128'h00);
        chk("ref7c", 128'(isb[8'h7c]), 128'h01);
        chk("ref00", 128'(isb[8'h00]), 128'h52);
        chk("ref52", 128'(isb[8'h52]), 128'h48);
        chk("ref16", 128'(isb[8'h16]), 128'hff);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < N; i++) begin
            chk("rst_ir", 128'(ir[i]), 128'(1));
            chk("rst_ov", 128'(ov[i]), 128'(0));
            chk("rst_os", os[i], 128'h0);
        end

        // LANES=1 known vector and latency
        send(0, 128'h76abd7fe2b670130c56f6bf27b777c63, k);
        iv[0] = 0;
        wait_ov(0, n);
        chk("lat_l1", 128'(n), 128'(16 + P));
        chk("vec_l1", os[0], 128'h0f0e0d0c0b0a09080706050403020100);

        // backpressure with ignored input pulses
        r = os[0];
        for (int c = 0; c < 10; c++) begin
            iv[0] = c[0];
            is_[0] = {4{$urandom()}};
            @(posedge clk);
            #1;
            chk("bp_hold", {ov[0], ir[0], os[0]}, {1'b1, 1'b0, r});
        end
        iv[0] = 0;
        orr[0] = 1;
        @(posedge clk);
        #1;
        orr[0] = 0;
        chk("bp_release", {ov[0], ir[0]}, {1'b0, 1'b1});

        // reset while cnt=7
        send(0, 128'h00112233445566778899aabbccddeeff, k);
        iv[0] = 0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("mid_rst", {ov[0], ir[0], bz[0], os[0]},
            {1'b0, 1'b1, 1'b0, 128'h0});
        send(0, {16{8'h52}}, k);
        iv[0] = 0;
        orr[0] = 1;
        wait_ov(0, n);
        chk("vec_52", os[0], {16{8'h48}});
        @(posedge clk);
        #1;
        orr[0] = 0;

        // LANES=16 single-edge substitution
        orr[2] = 1;
        send(2, {16{8'h16}}, k);
        iv[2] = 0;
        wait_ov(2, n);
        chk("lat_l16", 128'(n), 128'(1 + P));
        chk("vec_16", os[2], {16{8'hff}});
        send(2, {16{8'h63}}, k);
        iv[2] = 0;
        wait_ov(2, n);
        chk("vec_63", os[2], {16{8'h00}});

        // LANES=4 back-to-back over all 256 byte values
        orr[1] = 1;
        send(1, 128'h0, k);
        iv[1] = 0;
        wait_ov(1, n);
        chk("lat_l4", 128'(n), 128'(4 + P));
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 16; j++) begin
            for (int b = 0; b < 16; b++) st[b*8 +: 8] = 8'(16 * j + b);
            send(1, st, t[j]);
        end
        iv[1] = 0;
        chk("b2b_gap0", 128'(t[1] - t[0]), 128'(4 + P + 2));
        chk("b2b_gap1", 128'(t[2] - t[1]), 128'(4 + P + 2));
        wait_ov(1, n);
        for (int b = 0; b < 16; b++) st[b*8 +: 8] = isb[8'(240 + b)];
        chk("last_blk", os[1], st);
        repeat (4) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
